// File: rtl/oled_spi_pkg.sv
// oled_spi_pkg
//   Shared definitions for the OLED SPI arbiter slice.
//   - SPI_BYTE_W  : width of one SPI transfer
//   - arb_state_t : arbiter FSM state encoding (also exported on state_dbg)
package oled_spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    HOLD = 3'd4
  } arb_state_t;

endpackage

// File: rtl/oled_arb_picker.sv
// oled_arb_picker
//   Combinational winner selection among eligible requesters.
//   Configuration macro: OLED_SPI_ARB_RR_EN
//     defined   : round robin, search starts at ptr+1 (mod NUM_REQ)
//     undefined : fixed priority, lowest eligible index wins (ptr unused)
// Ports:
//   elig    in  NUM_REQ  eligible requesters
//   ptr     in  PW       index of the most recent IDLE winner
//   win     out NUM_REQ  one-hot winner, zero when nothing is eligible
//   win_idx out PW       binary index of the winner
module oled_arb_picker #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PW-1:0]      win_idx
);

  logic found;

`ifdef OLED_SPI_ARB_RR_EN
  int j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    // Walk NUM_REQ slots starting just after the previous winner.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[PW'(j)]) begin
        found           = 1'b1;
        win[PW'(j)]     = 1'b1;
        win_idx         = PW'(j);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter
//   Registered arbiter sharing one byte-wide SPI master between NUM_REQ
//   requesters (index 0 = init sequencer). Supports burst locking, optional
//   round-robin fairness and a watchdog on spi_send_done.
//   Configuration macro: OLED_SPI_ARB_RR_EN (round robin when defined,
//   fixed lowest-index priority otherwise).
// Handshake: a requester holds req/req_dc/req_data/req_lock stable from
//   assertion until the edge that ends its byte_done cycle, then advances
//   to its next byte or drops req; spi_send is a one-cycle start strobe and
//   spi_send_done a one-cycle completion strobe honoured only in WAIT.
// Ports:
//   clk, reset             clock (SPI domain), async active-high reset
//   init_done              low: only requester 0 may win arbitration
//   req/req_lock/req_dc    per-requester request, burst lock, D/C bit
//   req_data               byte i at [8i+7:8i]
//   grant, byte_done       current owner, per-owner completion pulse
//   spi_send/spi_data/dc   towards the SPI master
//   spi_send_done          completion pulse from the SPI master
//   timeout_err            sticky watchdog flag
//   state_dbg              current FSM state
module oled_spi_arbiter
  import oled_spi_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_done,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ-1:0]      req_dc,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      byte_done,
  output logic                    spi_send,
  output logic [SPI_BYTE_W-1:0]   spi_data,
  output logic                    dc,
  input  logic                    spi_send_done,
  output logic                    timeout_err,
  output arb_state_t              state_dbg
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t           state;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   pick_win;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        owner;
  logic [PW-1:0]        ptr;
  logic [WDW-1:0]       wdog;
  logic [SPI_BYTE_W-1:0] req_bytes [NUM_REQ];

  assign state_dbg = state;

  // Before init completes only the init sequencer competes.
  assign elig = req & (init_done ? {NUM_REQ{1'b1}} : NUM_REQ'(1));

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = req_data[k*SPI_BYTE_W +: SPI_BYTE_W];
    end
  end

`ifdef OLED_SPI_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= PW'(NUM_REQ - 1);
    end else if (state == IDLE && (|elig)) begin
      ptr <= pick_idx;
    end
  end
`else
  assign ptr = PW'(NUM_REQ - 1);
`endif

  oled_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .elig    (elig),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      byte_done   <= '0;
      spi_send    <= 1'b0;
      spi_data    <= '0;
      dc          <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      owner       <= '0;
    end else begin
      byte_done <= '0;
      spi_send  <= 1'b0;
      case (state)
        IDLE: begin
          if (|elig) begin
            spi_data <= req_bytes[pick_idx];
            dc       <= req_dc[pick_idx];
            grant    <= pick_win;
            owner    <= pick_idx;
            spi_send <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (spi_send_done) begin
            byte_done <= grant;
            state     <= DONE;
          end else if (wdog == WDW'(TIMEOUT_CYC - 1)) begin
            // This is the TIMEOUT_CYC-th WAIT cycle without completion.
            timeout_err <= 1'b1;
            grant       <= '0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          if (req_lock[owner]) begin
            state <= HOLD;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        HOLD: begin
          // A held grant bypasses the init_done mask.
          if (req[owner]) begin
            spi_data <= req_bytes[owner];
            dc       <= req_dc[owner];
            spi_send <= 1'b1;
            state    <= SEND;
          end else if (!req_lock[owner]) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/oled_spi_arbiter.md
# oled_spi_arbiter

Shares the single byte-wide SPI master of the OLED path between several requesters: the init sequencer, the frame drawer and any later command sources such as contrast or scroll control. It replaces the ad-hoc `init_done` mux in front of the SPI master with a registered arbiter. The arbiter supports burst locking and round-robin fairness, and it has a watchdog for a stuck `spi_send_done`. It sits between the requesters and the SPI master, in the `spi_clk` domain.

## Interface
- `NUM_REQ`, default 3: number of requesters, at least 2. Index 0 is the init sequencer.
- `TIMEOUT_CYC`, default 1024: maximum number of WAIT cycles allowed before a transfer is aborted.
- `clk`  in  1  block clock (the SPI clock domain)
- `reset`  in  1  reset, asynchronous and active-high
- `init_done`  in  1  while low, only requester 0 is eligible
- `req`  in  NUM_REQ  level signal: the requester has a byte pending
- `req_lock`  in  NUM_REQ  keep the grant after the current byte (burst)
- `req_dc`  in  NUM_REQ  D/C bit for each requester's byte
- `req_data`  in  8*NUM_REQ  byte i occupies bits [8i+7:8i]
- `grant`  out  NUM_REQ  one-hot or zero; the current owner
- `byte_done`  out  NUM_REQ  one-cycle pulse when the owner's byte is complete
- `spi_send`  out  1  one-cycle start pulse to the SPI master
- `spi_data`  out  8  byte to the SPI master
- `dc`  out  1  D/C bit to the SPI master
- `spi_send_done`  in  1  one-cycle completion pulse from the SPI master
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- Eligibility mask: `elig = req & (init_done ? all-ones : 1)`.
- The FSM has five states: IDLE, SEND, WAIT, DONE and HOLD. All outputs are registered.
- IDLE: `grant = 0`. If `elig != 0`, pick the winner w, then:
  - latch `req_data[w]` into `spi_data` and `req_dc[w]` into `dc`;
  - set `grant = onehot(w)`;
  - go to SEND.
- SEND: `spi_send = 1` for exactly one cycle, then go to WAIT.
- WAIT: `spi_send = 0` and the watchdog counts cycles.
  - On `spi_send_done`, go to DONE.
  - If the count reaches TIMEOUT_CYC, set `timeout_err = 1`, clear `grant` and go to IDLE. No `byte_done` pulse is issued.
- DONE: pulse `byte_done[w] = 1` for one cycle. No arbitration takes place in this state.
  - If `req_lock[w]`, go to HOLD. Otherwise clear `grant` and go to IDLE.
  - During this cycle the requester advances to its next byte or drops `req`.
- HOLD: `grant` is kept.
  - If `req[w]`, latch the byte and go to SEND. The `init_done` mask is not re-applied to a held grant.
  - Else if `!req_lock[w]`, clear `grant` and go to IDLE.
  - Else stay in HOLD.
- Requester rules:
  - Hold `req`, `req_dc`, `req_data` and `req_lock` stable from assertion until the `byte_done` edge.
  - Deassert `req_lock` with the last byte of a burst.
- `spi_data` and `dc` hold their last value until the next latch.
- `spi_send_done` is ignored outside WAIT.
- `init_done` changing mid-transfer does not affect the byte in flight. The mask applies at the next IDLE arbitration.

## Timing
- `req` sampled high in IDLE at edge N: `grant` and `spi_send` are high in cycle N+1, and WAIT starts in cycle N+2.
- `spi_send_done` sampled at edge M: `byte_done` is high in cycle M+1 (DONE), and the next `spi_send` occurs no earlier than cycle M+3.
- Reset values:
  - `grant = 0`, `byte_done = 0`, `spi_send = 0`, `spi_data = 8'h00`, `dc = 0`, `timeout_err = 0`;
  - state is IDLE, the watchdog is 0, and the round-robin pointer is NUM_REQ-1.
- Reset asserted mid-transfer aborts immediately to these values without a `byte_done` pulse. The SPI master is reset independently.
- Watchdog width is `$clog2(TIMEOUT_CYC+1)`. It clears on entry to WAIT. The abort happens on the TIMEOUT_CYC-th WAIT cycle.
- `timeout_err` is cleared only by reset.

## Configuration
- Macro `OLED_SPI_ARB_RR_EN`.
- Defined: round-robin arbitration. The search starts at pointer+1 modulo NUM_REQ, and the pointer updates to w on each IDLE grant.
- Undefined: fixed priority, where the lowest eligible index wins. The pointer logic is not compiled.

## Structure
- Package `oled_spi_pkg` holds:
  - the state enum typedef (IDLE, SEND, WAIT, DONE, HOLD);
  - the `SPI_BYTE_W = 8` constant.
- One sub-module, `oled_arb_picker`: a combinational function from `elig` and `ptr` to a one-hot winner. It is parameterised by NUM_REQ, and its round-robin path is under the macro.

## Test plan
- Init gating: with `init_done = 0`, `req = 3'b110` produces no grant. Raising `req[0]` with `req_data[0] = 8'hAE` and `req_dc[0] = 0` gives `grant = 3'b001`, a single `spi_send` pulse with `spi_data = 8'hAE`, and `byte_done[0]` one cycle after `spi_send_done`.
- Burst lock: requester 1 sends 4 bytes with `req_lock` high on the first three while requester 2 requests continuously. `grant` stays 3'b010 for all 4 bytes and switches to 3'b100 only after the 4th `byte_done`.
- Round robin, with `OLED_SPI_ARB_RR_EN` and `init_done = 1`: `req = 3'b111` held constant gives the grant order 0, 1, 2, 0. With the macro undefined, the order is 0, 0, 0.
- Timeout: with `TIMEOUT_CYC = 16` and `spi_send_done` held low, `timeout_err` rises on the 16th WAIT cycle, `grant` is 0, there is no `byte_done`, and the next request is served normally.
- Reset mid-WAIT: asserting `reset` asynchronously sets all outputs to their reset values in the same cycle. After release, a pending `req[0]` is granted at N+1.
- Stray done: a `spi_send_done` pulse in IDLE or HOLD causes no `byte_done` pulse and no state change.
